sbox_layer_seq: RTL and testbench
=================================

SBOX_LAYER_SEQ -- requirements
Module: sbox_layer_seq

Interface
REQ-001 The block SHALL have parameter NWORDS, default 8: number of 6-bit words per state. State width W = 6*NWORDS.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data/key valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept a state.
REQ-006 The block SHALL have port in_data, input, W bits: state; word i = bits [6i+5:6i].
REQ-007 The block SHALL have port key, input, W bits: round key, sampled with in_data.
REQ-008 The block SHALL have port sb_x, output, 6 bits: word presented to the external combinational 6-bit S-box core.
REQ-009 The block SHALL have port sb_y, input, 6 bits: S-box core output for sb_x, valid in the same cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 The block SHALL have port out_data, output, W bits: substituted state.
REQ-013 The block SHALL have port busy, output, 1 bit: FSM in RUN.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 A transfer SHALL occur on in_valid&&in_ready at a rising edge; the block SHALL then register in_data (XOR key per REQ-028), clear idx to 0, and enter RUN.
REQ-017 In RUN, sb_x SHALL equal registered word idx, combinationally.
REQ-018 Each RUN cycle, sb_y SHALL be written into result word idx, and idx SHALL increment.
REQ-019 After idx = NWORDS-1 is processed, the FSM SHALL enter DONE.
REQ-020 Latency: with transfer at edge 0, RUN SHALL occupy cycles 1..NWORDS and out_valid SHALL be 1 from cycle NWORDS+1 (cycle 9 for the default).
REQ-021 In DONE, out_valid SHALL be 1 and out_data SHALL stay stable until out_valid&&out_ready; then the FSM SHALL return to IDLE.
REQ-022 There SHALL be no accept in the same cycle as out handshake; in_ready SHALL rise the cycle after.
REQ-023 Outside RUN, sb_x SHALL be 6'h00; busy SHALL be 1 exactly in RUN.
REQ-024 out_data SHALL hold its last value outside DONE; it SHALL not be cleared on the out handshake.
REQ-025 in_valid SHALL be ignored in RUN and DONE; in_data and key SHALL not be sampled then.

Reset
REQ-026 On rst=1 at a rising edge, the FSM SHALL go to IDLE, idx to 0, the state register and out_data to 0, and out_valid to 0; in_ready SHALL be 1 from the following cycle.
REQ-027 rst SHALL override any handshake in the same cycle; a reset mid-RUN or in DONE SHALL discard the operation with no output.

Configuration
REQ-028 Macro SBOX_LAYER_KEYADD_EN SHALL control key addition. When defined, the registered state SHALL be in_data^key. When undefined, the registered state SHALL be in_data, and key SHALL be ignored while the port stays present.

Verification
REQ-029 The bench S-box model SHALL be sb_y=~sb_x for all scenarios except REQ-033. Scenario: macro defined, in_data=0, key=0, out_ready=1 -> out_valid at cycle 9 with out_data=48'hFFFFFFFFFFFF, then in_ready=1 at cycle 10.
REQ-030 Scenario: macro defined, in_data=key=48'h123456789ABC -> out_data=48'hFFFFFFFFFFFF.
REQ-031 Scenario: macro undefined, same stimulus as REQ-030 -> out_data=48'hEDCBA9876543.
REQ-032 Scenario: out_ready=0 for 5 cycles after out_valid -> out_valid and out_data held, in_ready=0 and in_valid ignored, release completes in one cycle.
REQ-033 Scenario: S-box model sb_y=sb_x+1 mod 64, in_data=48'h000000000000 -> sb_x=0 on cycles 1..8 and out_data=48'h041041041041.
REQ-034 Scenario: rst pulsed at cycle 4 of RUN -> at the next cycle busy=0, out_valid=0, in_ready=1, and out_data=0; a fresh transfer then completes normally.

Source files
------------

// File: rtl/sbox_layer_seq.sv
// sbox_layer_seq: word-serial 6-bit S-box layer over an NWORDS-word state using one external S-box core.
// Define SBOX_LAYER_KEYADD_EN to XOR the round key into the state on load.
module sbox_layer_seq #(
  parameter int NWORDS = 8,
  localparam int W = 6*NWORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] key,
  output logic [5:0]   sb_x,
  input  logic [5:0]   sb_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0] st_q, st_d, out_q, out_d, load;
  logic last;
`ifdef SBOX_LAYER_KEYADD_EN
  assign load = in_data ^ key;
`else
  logic unused_key;
  assign load = in_data;
  assign unused_key = ^key;
`endif
  assign last = idx_q == IW'(NWORDS-1);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q == RUN;
  assign sb_x = busy ? st_q[6*idx_q +: 6] : 6'h00;
  assign out_data = out_q;
  // substitution is done in place; out_q only updates on the final word so it holds outside DONE
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    st_d = st_q;
    out_d = out_q;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      idx_d = '0;
      st_d = load;
    end
    if (state_q == RUN) begin
      st_d[6*idx_q +: 6] = sb_y;
      idx_d = last ? '0 : idx_q + 1'b1;
      state_d = last ? DONE : RUN;
      out_d = last ? st_d : out_q;
    end
    if (state_q == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      st_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      st_q <= st_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_sbox_layer_seq.sv
// tb_sbox_layer_seq: randomized self-checking bench with a word-wise reference model of the S-box layer.
module tb_sbox_layer_seq;
  localparam int N = 8;
  localparam int W = 6*N;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [W-1:0] in_data = '0, key = '0, out_data;
  logic [5:0] sb_x, sb_y;
  bit sb_inc = 0;
  int checks = 0, errors = 0;

  sbox_layer_seq #(.NWORDS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .key(key), .sb_x(sb_x), .sb_y(sb_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;
  assign sb_y = sb_inc ? sb_x + 6'd1 : ~sb_x;

  function automatic logic [W-1:0] keyed(input logic [W-1:0] d, input logic [W-1:0] k);
`ifdef SBOX_LAYER_KEYADD_EN
    return d ^ k;
`else
    return d;
`endif
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [W-1:0] k, input bit inc);
    logic [W-1:0] s, r;
    s = keyed(d, k);
    for (int i = 0; i < N; i++) r[6*i +: 6] = inc ? s[6*i +: 6] + 6'd1 : ~s[6*i +: 6];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [W-1:0] d, input logic [W-1:0] k);
    in_data = d;
    key = k;
    in_valid = 1;
    tick();
    in_valid = 0;
    in_data = {$urandom, $urandom};
    key = {$urandom, $urandom};
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    in_valid = 1;
    in_data = {$urandom, $urandom};
    tick();
    rst = 0;
    in_valid = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b out_valid=%b want 0 0", busy, out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++; if (sb_x !== 6'h00) begin errors++; $display("FAIL reset_sb_x got %h want 00", sb_x); end
    tick();
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_override busy=%b in_ready=%b want 0 1", busy, in_ready); end
  endtask

  task automatic test_zero();
    int lat;
    out_ready = 1;
    start('0, '0);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL zero_run busy=%b in_ready=%b want 1 0", busy, in_ready); end
    wait_out(lat);
    checks++; if (lat !== N+1) begin errors++; $display("FAIL zero_latency got %0d want %0d", lat, N+1); end
    checks++; if (out_data !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL zero_data got %h want ffffffffffff", out_data); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_release in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    checks++; if (out_data !== 48'hFFFFFFFFFFFF) begin errors++; $display("FAIL zero_hold got %h want ffffffffffff", out_data); end
  endtask

  task automatic test_fixed();
    int lat;
    logic [W-1:0] exp;
`ifdef SBOX_LAYER_KEYADD_EN
    exp = 48'hFFFFFFFFFFFF;
`else
    exp = 48'hEDCBA9876543;
`endif
    out_ready = 1;
    start(48'h123456789ABC, 48'h123456789ABC);
    wait_out(lat);
    checks++; if (lat !== N+1) begin errors++; $display("FAIL fixed_latency got %0d want %0d", lat, N+1); end
    checks++; if (out_data !== exp) begin errors++; $display("FAIL fixed_data got %h want %h", out_data, exp); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] d, k, exp;
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    exp = model(d, k, 0);
    out_ready = 0;
    start(d, k);
    wait_out(lat);
    checks++; if (lat !== N+1) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, N+1); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1;
      in_data = {$urandom, $urandom};
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_hold_flags cyc %0d out_valid=%b in_ready=%b busy=%b want 1 0 0", i, out_valid, in_ready, busy); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL bp_hold_data cyc %0d got %h want %h", i, out_data, exp); end
    end
    out_ready = 1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy); end
    in_valid = 0;
  endtask

  task automatic test_plus1();
    int lat;
    sb_inc = 1;
    out_ready = 1;
    start('0, '0);
    for (int c = 1; c <= N; c++) begin
      checks++; if (sb_x !== 6'h00 || busy !== 1'b1) begin errors++; $display("FAIL plus1_sb_x cyc %0d got %h busy=%b want 00 1", c, sb_x, busy); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 48'h041041041041) begin errors++; $display("FAIL plus1_data valid=%b got %h want 1 041041041041", out_valid, out_data); end
    tick();
    sb_inc = 0;
  endtask

  task automatic test_mid_reset();
    int lat;
    logic [W-1:0] d, k;
    out_ready = 1;
    start({$urandom, $urandom}, {$urandom, $urandom});
    tick(); tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL midrst_flags busy=%b out_valid=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL midrst_data got %h want 0", out_data); end
    d = {$urandom, $urandom};
    k = {$urandom, $urandom};
    start(d, k);
    wait_out(lat);
    checks++; if (lat !== N+1 || out_data !== model(d, k, 0)) begin errors++; $display("FAIL midrst_fresh lat=%0d got %h want %0d %h", lat, out_data, N+1, model(d, k, 0)); end
    out_ready = 0;
    tick();
    start({$urandom, $urandom}, '0);
    wait_out(lat);
    rst = 1;
    tick();
    rst = 0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin errors++; $display("FAIL donerst out_valid=%b in_ready=%b data=%h want 0 1 0", out_valid, in_ready, out_data); end
    out_ready = 1;
  endtask

  task automatic test_random();
    logic [W-1:0] d, k, s, exp;
    int hold;
    for (int n = 0; n < 25; n++) begin
      d = {$urandom, $urandom};
      k = {$urandom, $urandom};
      sb_inc = $urandom_range(0, 1);
      s = keyed(d, k);
      exp = model(d, k, sb_inc);
      out_ready = $urandom_range(0, 1);
      start(d, k);
      for (int c = 1; c <= N; c++) begin
        checks++; if (sb_x !== s[6*(c-1) +: 6]) begin errors++; $display("FAIL rand_sb_x iter %0d cyc %0d got %h want %h", n, c, sb_x, s[6*(c-1) +: 6]); end
        tick();
      end
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL rand_data iter %0d valid=%b got %h want 1 %h", n, out_valid, out_data, exp); end
      hold = out_ready ? 0 : $urandom_range(1, 4);
      for (int i = 0; i < hold; i++) tick();
      out_ready = 1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_data !== exp) begin errors++; $display("FAIL rand_release iter %0d in_ready=%b data=%h want 1 %h", n, in_ready, out_data, exp); end
    end
    sb_inc = 0;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [W-1:0] d;
    out_ready = 1;
    for (int n = 0; n < 4; n++) begin
      d = {$urandom, $urandom};
      start(d, '0);
      wait_out(lat);
      checks++; if (lat !== N+1 || out_data !== model(d, '0, 0)) begin errors++; $display("FAIL b2b iter %0d lat=%0d got %h want %0d %h", n, lat, out_data, N+1, model(d, '0, 0)); end
      tick();
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_zero();
    test_fixed();
    test_backpressure();
    test_plus1();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
